// File: rtl/filter_luma_8tap.sv
// 8-tap luma interpolation actor: multi-flux FIFO inputs, two-stage registered MAC,
// in-order output with backpressure. Interface bundles are flattened into packed per-port arrays.
module filter_luma_8tap #(
    parameter int FLUX        = 2,
    parameter int COEFF_WIDTH = 9,
    parameter int PIX_WIDTH   = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 0,
    localparam int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [7:0][TAG_WIDTH+COEFF_WIDTH-1:0]    i_c_dout,
    input  logic [7:0][FLUX-1:0]                     i_c_empty,
    output logic [7:0][FLUX-1:0]                     o_c_read,
    input  logic [7:0][TAG_WIDTH+PIX_WIDTH-1:0]      i_p_dout,
    input  logic [7:0][FLUX-1:0]                     i_p_empty,
    output logic [7:0][FLUX-1:0]                     o_p_read,
    output logic [TAG_WIDTH+OUT_WIDTH-1:0]           o_y_din,
    output logic                                     o_y_write,
    input  logic [FLUX-1:0]                          i_y_full
);

    localparam int PROD_W = COEFF_WIDTH + PIX_WIDTH + 1;
    localparam int SUM_W  = PROD_W + 3;
    localparam int ROUND  = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

    logic [FLUX-1:0]             w_ready;
    logic                        w_any;
    logic [TAG_WIDTH-1:0]        w_tag;
    logic                        w_advance;
    logic                        w_fire;
    logic [FLUX-1:0]             w_onehot;
    logic signed [PROD_W-1:0]    w_prod [8];
    logic signed [SUM_W-1:0]     w_sum;
    logic signed [SUM_W-1:0]     w_rnd;
    logic signed [SUM_W-1:0]     w_shift;
    logic                        w_unused_tag_bits;

    logic                        r_s1_valid;
    logic [TAG_WIDTH-1:0]        r_s1_tag;
    logic signed [PROD_W-1:0]    r_s1_prod [8];
    logic                        r_s2_valid;
    logic [TAG_WIDTH-1:0]        r_s2_tag;
    logic [OUT_WIDTH-1:0]        r_s2_data;

    always_comb begin
        w_ready = '1;
        for (int unsigned k = 0; k < 8; k++) begin
            w_ready &= ~(i_c_empty[k] | i_p_empty[k]);
        end
    end

    // Scan from the top so the lowest ready flux wins.
    always_comb begin
        w_any = 1'b0;
        w_tag = '0;
        for (int unsigned f = FLUX; f > 0; f--) begin
            if (w_ready[f-1]) begin
                w_any = 1'b1;
                w_tag = TAG_WIDTH'(f - 1);
            end
        end
    end

    assign w_advance = !r_s2_valid || !i_y_full[r_s2_tag];
    // Reads are combinational, so they must be gated off while reset is held.
    assign w_fire    = rst_n && w_any && w_advance;
    assign w_onehot  = FLUX'(1) << w_tag;

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            o_c_read[k] = w_fire ? w_onehot : '0;
            o_p_read[k] = w_fire ? w_onehot : '0;
        end
    end

    always_comb begin
        w_unused_tag_bits = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_prod[k] = PROD_W'($signed(i_c_dout[k][COEFF_WIDTH-1:0]))
                      * $signed({1'b0, i_p_dout[k][PIX_WIDTH-1:0]});
            w_unused_tag_bits ^= ^{i_c_dout[k][TAG_WIDTH+COEFF_WIDTH-1:COEFF_WIDTH],
                                   i_p_dout[k][TAG_WIDTH+PIX_WIDTH-1:PIX_WIDTH]};
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_sum += SUM_W'(r_s1_prod[k]);
        end
        w_rnd   = w_sum + SUM_W'(ROUND);
        w_shift = w_rnd >>> SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                r_s1_prod[k] <= '0;
            end
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_data  <= '0;
        end else begin
            if (w_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_tag   <= w_tag;
                for (int unsigned k = 0; k < 8; k++) begin
                    r_s1_prod[k] <= w_prod[k];
                end
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
            if (w_advance) begin
                r_s2_valid <= r_s1_valid;
                r_s2_tag   <= r_s1_tag;
                r_s2_data  <= OUT_WIDTH'(w_shift);
            end
        end
    end

    assign o_y_write = r_s2_valid && !i_y_full[r_s2_tag];
    assign o_y_din   = {r_s2_tag, r_s2_data};

endmodule

// File: tb/tb_filter_luma_8tap.sv
// Bench for filter_luma_8tap: per-port multi-flux FIFO models, write log, and a
// plain-arithmetic dot-product reference per token set.
`timescale 1ns/1ps
module tb_filter_luma_8tap;

    localparam int FLUX = 2, CW = 9, PW = 8, OW = 16, SHIFT = 0, MAXN = 128, MAXG = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0][CW:0]     c_dout;
    logic [7:0][FLUX-1:0] c_empty, c_read;
    logic [7:0][PW:0]     p_dout;
    logic [7:0][FLUX-1:0] p_empty, p_read;
    logic [OW:0]          y_din;
    logic                 y_write;
    logic [FLUX-1:0]      y_full;

    filter_luma_8tap #(.FLUX(FLUX), .COEFF_WIDTH(CW), .PIX_WIDTH(PW), .OUT_WIDTH(OW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_c_dout(c_dout), .i_c_empty(c_empty), .o_c_read(c_read),
        .i_p_dout(p_dout), .i_p_empty(p_empty), .o_p_read(p_read),
        .o_y_din(y_din), .o_y_write(y_write), .i_y_full(y_full)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int coef_m [FLUX][MAXN][8];
    int pix_m  [FLUX][MAXN][8];
    logic [15:0] exp_val [FLUX][MAXN];
    int head [FLUX][16];
    int avail [FLUX][16];
    bit pend [FLUX][16];
    int nslot [FLUX];
    int rd_cnt [FLUX][16];
    int got_tag [MAXG];
    logic [15:0] got_dat [MAXG];
    int got_cyc [MAXG];
    int ngot = 0, nfire = 0, fire_cyc = 0, bad_cnt = 0, incons = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed dot product, optional rounded shift, keep the low 16 bits.
    function automatic logic [15:0] ref_slot(input int f, input int s);
        int acc = 0;
        for (int k = 0; k < 8; k++) acc += coef_m[f][s][k] * pix_m[f][s][k];
        if (SHIFT > 0) acc = (acc + (1 << ((SHIFT > 0) ? SHIFT - 1 : 0))) >>> SHIFT;
        return acc[15:0];
    endfunction

    always @(negedge clk) begin
        #1;
        for (int k = 0; k < 8; k++)
            for (int f = 0; f < FLUX; f++) begin
                c_empty[k][f] = head[f][k] >= avail[f][k];
                p_empty[k][f] = head[f][k+8] >= avail[f][k+8];
            end
    end

    // dout presents the head of whichever flux the actor is reading.
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 8; k++) begin
            int sc, sp;
            sc = 0; sp = 0;
            for (int f = FLUX - 1; f >= 0; f--) begin
                if (c_read[k][f]) sc = f;
                if (p_read[k][f]) sp = f;
            end
            c_dout[k] = {1'(sc), 9'(coef_m[sc][head[sc][k] % MAXN][k])};
            p_dout[k] = {1'(sp), 8'(pix_m[sp][head[sp][k+8] % MAXN][k])};
        end
    end

    always @(negedge clk) begin
        #3;
        if (y_write && ngot < MAXG) begin
            got_tag[ngot] = int'(y_din[OW]);
            got_dat[ngot] = y_din[OW-1:0];
            got_cyc[ngot] = cyc;
            if (y_full[y_din[OW]]) bad_cnt++;
            ngot++;
        end
        for (int k = 0; k < 16; k++) begin
            logic [FLUX-1:0] rv, ev;
            rv = (k < 8) ? c_read[k%8] : p_read[k%8];
            ev = (k < 8) ? c_empty[k%8] : p_empty[k%8];
            if ((rv & ev) != 0 || $countones(rv) > 1) bad_cnt++;
            if (rv != c_read[0]) incons++;
            for (int f = 0; f < FLUX; f++)
                if (rv[f]) begin pend[f][k] = 1'b1; rd_cnt[f][k]++; end
        end
        if (c_read[0] != 0) begin nfire++; fire_cyc = cyc; end
    end

    always @(posedge clk) begin
        #1;
        for (int f = 0; f < FLUX; f++)
            for (int k = 0; k < 16; k++)
                if (pend[f][k]) begin head[f][k]++; pend[f][k] = 1'b0; end
    end

    task automatic alloc(input int f, output int s);
        s = nslot[f];
        nslot[f]++;
    endtask

    task automatic fill_rand(input int f, input int s);
        for (int k = 0; k < 8; k++) begin
            coef_m[f][s][k] = int'($urandom_range(0, 511)) - 256;
            pix_m[f][s][k]  = int'($urandom_range(0, 255));
        end
        exp_val[f][s] = ref_slot(f, s);
    endtask

    task automatic expose(input int f, input int s, input logic [15:0] mask);
        for (int k = 0; k < 16; k++) if (mask[k]) avail[f][k] = s + 1;
    endtask

    task automatic wait_got(input int n, input int budget);
        int t = 0;
        while (ngot < n && t < budget) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_log;
        ngot = 0;
        nfire = 0;
        for (int f = 0; f < FLUX; f++) for (int k = 0; k < 16; k++) rd_cnt[f][k] = 0;
    endtask

    task automatic test_reset;
        int s, tot, ones;
        int c0[8] = '{0, 0, 0, 64, 0, 0, 0, 0};
        rst_n = 1'b0;
        y_full = '0;
        @(negedge clk);
        clear_log();
        alloc(0, s);
        for (int k = 0; k < 8; k++) begin coef_m[0][s][k] = c0[k]; pix_m[0][s][k] = 100; end
        exp_val[0][s] = ref_slot(0, s);
        expose(0, s, 16'hFFFF);
        repeat (3) @(negedge clk);
        #4;
        checks++; if (y_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b exp 0", y_write); end
        tot = 0;
        for (int k = 0; k < 16; k++) tot += rd_cnt[0][k] + rd_cnt[1][k];
        checks++; if (tot != 0) begin errors++; $display("FAIL reset_reads got %0d exp 0", tot); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_got(1, 20);
        checks++; if (ngot != 1) begin errors++; $display("FAIL single_count got %0d exp 1", ngot); end
        checks++; if (got_tag[0] != 0 || got_dat[0] !== 16'd6400)
            begin errors++; $display("FAIL single_value got %0d/%0d exp 0/6400", got_tag[0], got_dat[0]); end
        checks++; if (got_cyc[0] - fire_cyc != 2)
            begin errors++; $display("FAIL single_latency got %0d exp 2", got_cyc[0] - fire_cyc); end
        ones = 0;
        for (int k = 0; k < 16; k++) if (rd_cnt[0][k] == 1 && rd_cnt[1][k] == 0) ones++;
        checks++; if (ones != 16) begin errors++; $display("FAIL single_reads got %0d ports exp 16", ones); end
    endtask

    task automatic test_halfpel;
        int s;
        int c0[8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
        @(negedge clk);
        clear_log();
        alloc(1, s);
        for (int k = 0; k < 8; k++) begin coef_m[1][s][k] = c0[k]; pix_m[1][s][k] = 10 * (k + 1); end
        exp_val[1][s] = ref_slot(1, s);
        expose(1, s, 16'hFFFF);
        wait_got(1, 20);
        checks++; if (ngot != 1 || got_tag[0] != 1 || got_dat[0] !== 16'd2880)
            begin errors++; $display("FAIL halfpel got n=%0d %0d/%0d exp 1/2880", ngot, got_tag[0], got_dat[0]); end
    endtask

    task automatic test_extremes;
        int s0, s1;
        int c0[8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
        @(negedge clk);
        clear_log();
        alloc(0, s0);
        alloc(0, s1);
        for (int k = 0; k < 8; k++) begin
            coef_m[0][s0][k] = c0[k]; pix_m[0][s0][k] = (c0[k] > 0) ? 0 : 255;
            coef_m[0][s1][k] = c0[k]; pix_m[0][s1][k] = (c0[k] > 0) ? 255 : 0;
        end
        exp_val[0][s0] = ref_slot(0, s0);
        exp_val[0][s1] = ref_slot(0, s1);
        expose(0, s1, 16'hFFFF);
        wait_got(2, 20);
        checks++; if (ngot != 2) begin errors++; $display("FAIL extremes_count got %0d exp 2", ngot); end
        checks++; if (got_dat[0] !== 16'hE818) begin errors++; $display("FAIL extremes_neg got %h exp e818", got_dat[0]); end
        checks++; if (got_dat[1] !== 16'd22440) begin errors++; $display("FAIL extremes_pos got %0d exp 22440", got_dat[1]); end
        checks++; if (got_cyc[1] - got_cyc[0] != 1)
            begin errors++; $display("FAIL extremes_b2b gap %0d exp 1", got_cyc[1] - got_cyc[0]); end
    endtask

    task automatic test_priority;
        int b0, b1, s, ef, es;
        @(negedge clk);
        clear_log();
        b0 = nslot[0];
        b1 = nslot[1];
        for (int i = 0; i < 6; i++) begin
            alloc(0, s); fill_rand(0, s);
            alloc(1, s); fill_rand(1, s);
        end
        expose(0, b0 + 5, 16'hFFFF);
        expose(1, b1 + 5, 16'hFFFF);
        wait_got(12, 40);
        checks++; if (ngot != 12) begin errors++; $display("FAIL prio_count got %0d exp 12", ngot); end
        for (int i = 0; i < 12 && i < ngot; i++) begin
            ef = (i < 6) ? 0 : 1;
            es = ((ef == 0) ? b0 : b1) + (i % 6);
            checks++;
            if (got_tag[i] != ef || got_dat[i] !== exp_val[ef][es])
                begin errors++; $display("FAIL prio_out[%0d] got %0d/%h exp %0d/%h", i, got_tag[i], got_dat[i], ef, exp_val[ef][es]); end
        end
        checks++; if (ngot == 12 && got_cyc[11] - got_cyc[0] != 11)
            begin errors++; $display("FAIL prio_throughput span %0d exp 11", got_cyc[11] - got_cyc[0]); end
    endtask

    task automatic test_partial;
        int s0, s1, tot;
        @(negedge clk);
        clear_log();
        alloc(0, s0); fill_rand(0, s0);
        alloc(1, s1); fill_rand(1, s1);
        expose(0, s0, 16'h7FFF);
        expose(1, s1, 16'hFFFF);
        wait_got(1, 20);
        repeat (4) @(negedge clk);
        tot = 0;
        for (int k = 0; k < 16; k++) tot += rd_cnt[0][k];
        checks++; if (ngot != 1 || got_tag[0] != 1 || got_dat[0] !== exp_val[1][s1])
            begin errors++; $display("FAIL partial_other got n=%0d %0d/%h exp 1/%h", ngot, got_tag[0], got_dat[0], exp_val[1][s1]); end
        checks++; if (tot != 0) begin errors++; $display("FAIL partial_noread got %0d exp 0", tot); end
        expose(0, s0, 16'h8000);
        wait_got(2, 20);
        checks++; if (ngot != 2 || got_tag[1] != 0 || got_dat[1] !== exp_val[0][s0])
            begin errors++; $display("FAIL partial_done got n=%0d %0d/%h exp 0/%h", ngot, got_tag[1], got_dat[1], exp_val[0][s0]); end
    endtask

    task automatic test_back_to_back;
        int b, s;
        @(negedge clk);
        clear_log();
        y_full[0] = 1'b1;
        b = nslot[0];
        for (int i = 0; i < 3; i++) begin alloc(0, s); fill_rand(0, s); end
        expose(0, b + 2, 16'hFFFF);
        repeat (6) @(negedge clk);
        checks++; if (ngot != 0) begin errors++; $display("FAIL stall_nowrite got %0d exp 0", ngot); end
        checks++; if (rd_cnt[0][0] != 2 || rd_cnt[0][15] != 2)
            begin errors++; $display("FAIL stall_reads got %0d/%0d exp 2/2", rd_cnt[0][0], rd_cnt[0][15]); end
        y_full[0] = 1'b0;
        wait_got(3, 20);
        checks++; if (ngot != 3) begin errors++; $display("FAIL stall_count got %0d exp 3", ngot); end
        for (int i = 0; i < 3 && i < ngot; i++) begin
            checks++;
            if (got_tag[i] != 0 || got_dat[i] !== exp_val[0][b+i])
                begin errors++; $display("FAIL stall_out[%0d] got %0d/%h exp 0/%h", i, got_tag[i], got_dat[i], exp_val[0][b+i]); end
        end
        checks++; if (ngot == 3 && got_cyc[2] - got_cyc[0] != 2)
            begin errors++; $display("FAIL stall_b2b span %0d exp 2", got_cyc[2] - got_cyc[0]); end
    endtask

    task automatic test_random;
        int base [FLUX];
        int gidx [FLUX];
        int s, t, f, es;
        @(negedge clk);
        clear_log();
        bad_cnt = 0;
        incons = 0;
        for (int ff = 0; ff < FLUX; ff++) begin
            base[ff] = nslot[ff];
            gidx[ff] = 0;
            for (int i = 0; i < 40; i++) begin alloc(ff, s); fill_rand(ff, s); end
        end
        t = 0;
        while (ngot < 80 && t < 3000) begin
            @(negedge clk);
            t++;
            for (int ff = 0; ff < FLUX; ff++) begin
                y_full[ff] = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < 16; k++)
                    if (avail[ff][k] < nslot[ff] && $urandom_range(0, 1) == 1) avail[ff][k]++;
            end
        end
        y_full = '0;
        repeat (6) @(negedge clk);
        checks++; if (ngot != 80) begin errors++; $display("FAIL random_count got %0d exp 80", ngot); end
        for (int i = 0; i < ngot; i++) begin
            f = got_tag[i];
            es = base[f] + gidx[f];
            gidx[f]++;
            checks++;
            if (got_dat[i] !== exp_val[f][es])
                begin errors++; $display("FAIL random_out[%0d] flux %0d got %h exp %h", i, f, got_dat[i], exp_val[f][es]); end
        end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL random_protocol got %0d exp 0", bad_cnt); end
        checks++; if (incons != 0) begin errors++; $display("FAIL random_read_align got %0d exp 0", incons); end
    endtask

    task automatic test_reset_mid;
        int b, s;
        @(negedge clk);
        clear_log();
        y_full[0] = 1'b1;
        b = nslot[0];
        for (int i = 0; i < 3; i++) begin alloc(0, s); fill_rand(0, s); end
        expose(0, b + 2, 16'hFFFF);
        repeat (5) @(negedge clk);
        y_full[0] = 1'b0;
        #2;
        checks++; if (y_write !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b exp 1", y_write); end
        rst_n = 1'b0;
        #2;
        checks++; if (y_write !== 1'b0) begin errors++; $display("FAIL midreset_drop got %b exp 0", y_write); end
        checks++; if (c_read !== '0 || p_read !== '0)
            begin errors++; $display("FAIL midreset_read got %h/%h exp 0", c_read, p_read); end
        repeat (2) @(negedge clk);
        checks++; if (rd_cnt[0][0] != 2) begin errors++; $display("FAIL midreset_hold got %0d exp 2", rd_cnt[0][0]); end
        ngot = 0;
        rst_n = 1'b1;
        wait_got(1, 20);
        checks++; if (ngot != 1 || got_dat[0] !== exp_val[0][b+2])
            begin errors++; $display("FAIL midreset_first got n=%0d %h exp %h", ngot, got_dat[0], exp_val[0][b+2]); end
    endtask

    initial begin
        c_empty = '1;
        p_empty = '1;
        c_dout = '0;
        p_dout = '0;
        y_full = '0;
        test_reset();
        test_halfpel();
        test_extremes();
        test_priority();
        test_partial();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_luma_8tap.md
Name: filter_luma_8tap

Overview:
- Dataflow actor directly downstream of the luma coefficient generator.
- Consumes one 8-coefficient set (c0..c7) and eight 8-bit reference pixels (p0..p7) per firing, all from the same flux.
- Computes the 8-tap luma interpolation sum and emits one filtered sample token tagged with its flux.
- Multi-flux (FLUX tagged streams) through the shared read/write FIFO interfaces, with a registered two-stage MAC pipeline and output backpressure.

Parameters:
- FLUX, 2, number of tagged data fluxes; must be >=2. TAG_WIDTH = $clog2(FLUX).
- COEFF_WIDTH, 9, signed coefficient data width (excluding tag).
- PIX_WIDTH, 8, unsigned pixel data width (excluding tag).
- OUT_WIDTH, 16, signed output data width (excluding tag).
- SHIFT, 0, arithmetic right shift applied to the sum. If SHIFT>0, the rounding offset 1<<(SHIFT-1) is added before the shift.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- read_port_c0..read_port_c7, read_interface.actor, dout TAG_WIDTH+COEFF_WIDTH / empty FLUX / read FLUX, coefficient streams.
- read_port_p0..read_port_p7, read_interface.actor, dout TAG_WIDTH+PIX_WIDTH / empty FLUX / read FLUX, pixel streams.
- write_port_y, write_interface.actor, din TAG_WIDTH+OUT_WIDTH / write 1 / full FLUX, filtered output stream.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - s1_valid, s2_valid cleared; stage registers cleared.
  - write_port_y.write=0; all read[]=0 (read is combinational, so it is 0 during reset).
  - Reset is honoured at any time; in-flight tokens are discarded.
- Readiness and selection:
  - flux i is ready when empty[i]==0 on all 16 read ports.
  - The lowest ready index is selected as tag.
- Pipeline:
  - advance = !s2_valid | (s2_valid & !write_port_y.full[s2_tag]).
  - fire = (some flux ready) & advance.
- Firing:
  - On fire, the read[tag] bit is asserted on all 16 read ports in the same cycle; all other read bits are 0.
  - Without fire, no read bit is asserted.
  - Data bits come from dout[WIDTH-TAG_WIDTH-1:0].
- Stage 1 (registered on fire):
  - Eight products ck*pk, each a signed COEFF_WIDTH+PIX_WIDTH+1 bit value with the pixel zero-extended.
  - Tag is registered with the products; s1_valid<=1.
  - If advance is high and there is no fire, s1_valid<=0.
- Stage 2 (registered when advance):
  - Adder-tree sum of the 8 products at full precision (20 bits).
  - Rounding and shift applied, then the result is truncated to OUT_WIDTH.
  - Luma coefficient ranges guarantee no overflow for 16 bits at SHIFT=0.
  - s2_valid<=s1_valid, s2_tag<=s1_tag.
- Output:
  - write_port_y.write = s2_valid & !full[s2_tag] (combinational).
  - din = {s2_tag, s2_data}; din='x when write=0.
- Stall:
  - If s2_valid and full[s2_tag], both stages hold and no reads occur.
  - Stalling on one flux's full blocks all fluxes; ordering is strictly preserved.
- Latency and throughput:
  - Firing at cycle N gives write=1 at cycle N+2 when unstalled.
  - Throughput is 1 token/cycle.
- Simultaneous write and fire in the same cycle is legal; the pipeline shifts.
- Partial availability (some ports empty for a flux) means no firing for that flux and no partial reads.

Test Plan:
- Coefficient set {0,0,0,64,0,0,0,0}, flux0, all pixels 100 -> one write at N+2, din={0,16'd6400}; exactly one read pulse per port.
- Coefficients {-1,4,-11,40,40,-11,4,-1}, pixels 10,20,...,80 on flux1 -> din={1,16'd2880}.
- Same coefficients, pixels 0 on positive taps and 255 on negative taps -> din=-6120 (16'hE818); pixels 255 on positive taps and 0 on negative taps -> 22440.
- Flux0 and flux1 both ready every cycle -> flux0 tokens issued first; flux1 fires only when flux0 is empty. Outputs must match the golden model in order.
- Three back-to-back flux0 firings with full[0] forced high for 5 cycles from first output -> write held 0, no reads while both stages are full, then three consecutive writes with correct values and no loss or duplication.
- rst_n pulsed low mid-stream with both stages valid -> write drops to 0 immediately; after release, the first output corresponds to the first post-reset firing only.
